// File: rtl/pipelined_16bit_fp_adder.sv
// ---------------------------------------------------------------------------
// pipelined_16bit_fp_adder
//
// IEEE 754 binary16 adder/subtractor split into four stages with three
// register banks between them:
//   stage 1  unpack, special detection, swap, align      -> bank 1
//   stage 2  significand add/subtract                    -> bank 2
//   stage 3  normalize (LZC/left shift or carry shift)   -> bank 3
//   stage 4  round per captured mode, overflow, pack     -> s (combinational)
// A pair captured on an enabled edge appears on s after the 3rd enabled edge.
//
// Ports:
//   a, b   operands (binary16)
//   sub    0: a+b, 1: a-b
//   rm     00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
//   s      result (binary16), driven from bank 3
//   clk    rising-edge clock
//   clrn   asynchronous active-low clear of all banks
//   e      enable; every bank loads only when e=1
// ---------------------------------------------------------------------------
module pipelined_16bit_fp_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    input  logic [1:0]  rm,
    output logic [15:0] s,
    input  logic        clk,
    input  logic        clrn,
    input  logic        e
);

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RDN = 2'b01,
        RM_RUP = 2'b10,
        RM_RTZ = 2'b11
    } rm_e;

    localparam logic [15:0] QNAN = 16'h7E00;

    // ------------------------------------------------------------------
    // Stage 1: unpack, specials, swap, align
    // ------------------------------------------------------------------
    logic        w1_sa, w1_sb;
    logic [4:0]  w1_ea, w1_eb, w1_xa, w1_xb;
    logic [9:0]  w1_fa, w1_fb;
    logic [10:0] w1_ma, w1_mb;
    logic        w1_a_nan, w1_b_nan, w1_a_inf, w1_b_inf;
    logic        w1_a_big;
    logic        w1_sign;
    logic [4:0]  w1_exp_l, w1_exp_s, w1_diff;
    logic [10:0] w1_m_l, w1_m_s;
    logic [27:0] w1_ext;
    logic [13:0] w1_aligned;
    logic        w1_special;
    logic [15:0] w1_special_val;

    assign w1_sa    = a[15];
    assign w1_sb    = b[15] ^ sub;           // subtraction = add with b negated
    assign w1_ea    = a[14:10];
    assign w1_eb    = b[14:10];
    assign w1_fa    = a[9:0];
    assign w1_fb    = b[9:0];
    assign w1_ma    = {|w1_ea, w1_fa};
    assign w1_mb    = {|w1_eb, w1_fb};
    // Subnormals share the scale of exponent 1.
    assign w1_xa    = (w1_ea == 5'd0) ? 5'd1 : w1_ea;
    assign w1_xb    = (w1_eb == 5'd0) ? 5'd1 : w1_eb;
    assign w1_a_nan = (&w1_ea) &  (|w1_fa);
    assign w1_b_nan = (&w1_eb) &  (|w1_fb);
    assign w1_a_inf = (&w1_ea) & ~(|w1_fa);
    assign w1_b_inf = (&w1_eb) & ~(|w1_fb);
    // Exponent:fraction order equals magnitude order for finite values.
    assign w1_a_big = (a[14:0] >= b[14:0]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
        w1_sign  = w1_sb;
        w1_exp_l = w1_xb;
        w1_m_l   = w1_mb;
        w1_exp_s = w1_xa;
        w1_m_s   = w1_ma;
        if (w1_a_big) begin
            w1_sign  = w1_sa;
            w1_exp_l = w1_xa;
            w1_m_l   = w1_ma;
            w1_exp_s = w1_xb;
            w1_m_s   = w1_mb;
        end
    end

    assign w1_diff = w1_exp_l - w1_exp_s;
    // Window [27:14] holds significand + guard/round/sticky; anything shifted
    // below it folds into sticky.
    assign w1_ext  = {w1_m_s, 3'b000, 14'd0} >> w1_diff;
    assign w1_aligned = (w1_diff >= 5'd14) ? {13'd0, |w1_m_s}
                                           : {w1_ext[27:15], w1_ext[14] | (|w1_ext[13:0])};

    always_comb begin
        w1_special     = 1'b0;
        w1_special_val = 16'h0000;
        if (w1_a_nan | w1_b_nan | (w1_a_inf & w1_b_inf & (w1_sa != w1_sb))) begin
            w1_special     = 1'b1;
            w1_special_val = QNAN;
        end else if (w1_a_inf) begin
            w1_special     = 1'b1;
            w1_special_val = {w1_sa, 15'h7C00};
        end else if (w1_b_inf) begin
            w1_special     = 1'b1;
            w1_special_val = {w1_sb, 15'h7C00};
        end
    end

    logic        r1_sign, r1_op_sub, r1_special;
    logic [4:0]  r1_exp;
    logic [10:0] r1_m_l;
    logic [13:0] r1_m_s;
    logic [15:0] r1_special_val;
    rm_e         r1_rm;

    // NOTE: state uses non-blocking assignments; the clear covers every bank so s reads 0 straight out of reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r1_sign        <= 1'b0;
            r1_op_sub      <= 1'b0;
            r1_special     <= 1'b0;
            r1_exp         <= 5'd0;
            r1_m_l         <= 11'd0;
            r1_m_s         <= 14'd0;
            r1_special_val <= 16'h0000;
            r1_rm          <= RM_RNE;
        end else if (e) begin
            r1_sign        <= w1_sign;
            r1_op_sub      <= w1_sa ^ w1_sb;
            r1_special     <= w1_special;
            r1_exp         <= w1_exp_l;
            r1_m_l         <= w1_m_l;
            r1_m_s         <= w1_aligned;
            r1_special_val <= w1_special_val;
            r1_rm          <= rm_e'(rm);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: add/subtract; larger operand first so the difference is >= 0
    // ------------------------------------------------------------------
    logic [14:0] w2_l, w2_sum;

    assign w2_l   = {1'b0, r1_m_l, 3'b000};
    assign w2_sum = r1_op_sub ? (w2_l - {1'b0, r1_m_s}) : (w2_l + {1'b0, r1_m_s});

    logic        r2_sign, r2_op_sub, r2_special;
    logic [4:0]  r2_exp;
    logic [14:0] r2_sum;
    logic [15:0] r2_special_val;
    rm_e         r2_rm;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r2_sign        <= 1'b0;
            r2_op_sub      <= 1'b0;
            r2_special     <= 1'b0;
            r2_exp         <= 5'd0;
            r2_sum         <= 15'd0;
            r2_special_val <= 16'h0000;
            r2_rm          <= RM_RNE;
        end else if (e) begin
            r2_sign        <= r1_sign;
            r2_op_sub      <= r1_op_sub;
            r2_special     <= r1_special;
            r2_exp         <= r1_exp;
            r2_sum         <= w2_sum;
            r2_special_val <= r1_special_val;
            r2_rm          <= r1_rm;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalize
    // ------------------------------------------------------------------
    logic [3:0]  w3_lz;
    logic [4:0]  w3_lim, w3_shamt;
    logic [13:0] w3_shifted;
    logic [5:0]  w3_exp;
    logic [9:0]  w3_frac;
    logic        w3_g, w3_rs, w3_zero, w3_sign;

    always_comb begin
        w3_lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (r2_sum[i]) w3_lz = 4'(13 - i);
        end
    end

    always_comb begin
        // Left shift may not take the exponent below 1; what remains is subnormal.
        w3_lim     = r2_exp - 5'd1;
        w3_shamt   = ({1'b0, w3_lz} > w3_lim) ? w3_lim : {1'b0, w3_lz};
        w3_shifted = r2_sum[13:0] << w3_shamt;
        w3_zero    = (r2_sum == 15'd0);
        if (r2_sum[14]) begin
            w3_exp  = {1'b0, r2_exp} + 6'd1;
            w3_frac = r2_sum[13:4];
            w3_g    = r2_sum[3];
            w3_rs   = |r2_sum[2:0];
        end else begin
            // Hidden bit clear after the limited shift means exponent field 0.
            w3_exp  = w3_shifted[13] ? ({1'b0, r2_exp} - {1'b0, w3_shamt}) : 6'd0;
            w3_frac = w3_shifted[12:3];
            w3_g    = w3_shifted[2];
            w3_rs   = |w3_shifted[1:0];
        end
        // Exact cancellation gives +0, or -0 when rounding toward -inf;
        // adding like-signed zeros keeps their sign.
        w3_sign = r2_sign;
        if (w3_zero) w3_sign = r2_op_sub ? (r2_rm == RM_RDN) : r2_sign;
    end

    logic        r3_sign, r3_g, r3_rs, r3_zero, r3_special;
    logic [5:0]  r3_exp;
    logic [9:0]  r3_frac;
    logic [15:0] r3_special_val;
    rm_e         r3_rm;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r3_sign        <= 1'b0;
            r3_g           <= 1'b0;
            r3_rs          <= 1'b0;
            r3_zero        <= 1'b0;
            r3_special     <= 1'b0;
            r3_exp         <= 6'd0;
            r3_frac        <= 10'd0;
            r3_special_val <= 16'h0000;
            r3_rm          <= RM_RNE;
        end else if (e) begin
            r3_sign        <= w3_sign;
            r3_g           <= w3_g;
            r3_rs          <= w3_rs;
            r3_zero        <= w3_zero;
            r3_special     <= r2_special;
            r3_exp         <= w3_exp;
            r3_frac        <= w3_frac;
            r3_special_val <= r2_special_val;
            r3_rm          <= r2_rm;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: round, overflow, pack
    // ------------------------------------------------------------------
    logic        w4_inc, w4_ovf, w4_to_inf;
    logic [15:0] w4_rounded;

    always_comb begin
        w4_inc = 1'b0;
        case (r3_rm)
            RM_RNE:  w4_inc = r3_g & (r3_rs | r3_frac[0]);
            RM_RDN:  w4_inc = r3_sign & (r3_g | r3_rs);
            RM_RUP:  w4_inc = ~r3_sign & (r3_g | r3_rs);
            default: w4_inc = 1'b0;
        endcase
    end

    // Incrementing exponent:fraction as one word lets a fraction carry
    // renormalize (and lift a subnormal into exponent 1) for free.
    assign w4_rounded = {r3_exp, r3_frac} + {15'd0, w4_inc};
    assign w4_ovf     = (w4_rounded[15:10] >= 6'd31);
    assign w4_to_inf  = (r3_rm == RM_RNE)
                      | ((r3_rm == RM_RDN) &  r3_sign)
                      | ((r3_rm == RM_RUP) & ~r3_sign);

    always_comb begin
        s = {r3_sign, w4_rounded[14:0]};
        if (r3_special)
            s = r3_special_val;
        else if (r3_zero)
            s = {r3_sign, 15'd0};
        else if (w4_ovf)
            s = w4_to_inf ? {r3_sign, 15'h7C00} : {r3_sign, 15'h7BFF};
    end

endmodule

// File: tb/tb_pipelined_16bit_fp_adder.sv
// ---------------------------------------------------------------------------
// Testbench for pipelined_16bit_fp_adder.
// The driver pushes an expected result per enabled cycle; a monitor tracks
// pipeline occupancy and pops/compares when a result reaches s, and checks
// that s holds during stalls. Expected values come from directed constants or
// from an exact-arithmetic reference model (values as integers in units of
// 2^-24, rounded by quotient/remainder).
// ---------------------------------------------------------------------------
module tb_pipelined_16bit_fp_adder;

    logic        clk = 1'b0;
    logic        clrn;
    logic        e;
    logic        sub;
    logic [1:0]  rm;
    logic [15:0] a, b, s;

    pipelined_16bit_fp_adder dut (
        .a    (a),
        .b    (b),
        .sub  (sub),
        .rm   (rm),
        .s    (s),
        .clk  (clk),
        .clrn (clrn),
        .e    (e)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h0000;
    logic [2:0]  mon_vld  = 3'b000;
    logic        mon_en;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: s=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: exact sum in units of 2^-24, then rounded to binary16.
    function automatic logic [15:0] fp_ref(input logic [15:0] x, input logic [15:0] y,
                                           input logic op_sub, input logic [1:0] mode);
        logic   sx, sy, sr, up, to_inf;
        int     ex, ey, ee;
        longint mx, my, total, mag, q, rem, half;
        sx = x[15];
        sy = y[15] ^ op_sub;
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        if ((ex == 31 && x[9:0] != 0) || (ey == 31 && y[9:0] != 0)) return 16'h7E00;
        if (ex == 31 && ey == 31) return (sx == sy) ? {sx, 15'h7C00} : 16'h7E00;
        if (ex == 31) return {sx, 15'h7C00};
        if (ey == 31) return {sy, 15'h7C00};
        mx = (ex == 0) ? longint'(x[9:0]) : (longint'(1024 + int'(x[9:0])) << (ex - 1));
        my = (ey == 0) ? longint'(y[9:0]) : (longint'(1024 + int'(y[9:0])) << (ey - 1));
        total = (sx ? -mx : mx) + (sy ? -my : my);
        if (total == 0) return (sx == sy) ? {sx, 15'h0000} : ((mode == 2'b01) ? 16'h8000 : 16'h0000);
        sr  = (total < 0);
        mag = sr ? -total : total;
        ee  = 1;
        while (ee < 31 && mag >= (longint'(2048) << (ee - 1))) ee++;
        q = 0;
        if (ee < 31) begin
            q    = mag >> (ee - 1);
            rem  = mag - (q << (ee - 1));
            half = (longint'(1) << (ee - 1)) / 2;
            case (mode)
                2'b00:   up = (rem != 0) && ((rem > half) || (rem == half && q[0]));
                2'b01:   up = sr && (rem != 0);
                2'b10:   up = !sr && (rem != 0);
                default: up = 1'b0;
            endcase
            q = q + longint'(up);
            if (q == 2048) begin
                q  = 1024;
                ee = ee + 1;
            end
        end
        if (ee >= 31) begin
            to_inf = (mode == 2'b00) || (mode == 2'b01 && sr) || (mode == 2'b10 && !sr);
            return to_inf ? {sr, 15'h7C00} : {sr, 15'h7BFF};
        end
        if (q < 1024) return {sr, 5'd0, q[9:0]};
        return {sr, 5'(ee), q[9:0]};
    endfunction

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v[14:10] = 5'd0;
            1: begin
                v[14:10] = 5'd31;
                if ($urandom_range(0, 1) == 1) v[9:0] = 10'd0;
            end
            2: v[14:10] = 5'd30;
            3: v[14:0]  = 15'd0;
            default: ;
        endcase
        return v;
    endfunction

    // Drive one operation for the next rising edge and record its expectation.
    task automatic drive(input logic [15:0] xa, input logic [15:0] xb, input logic xsub,
                         input logic [1:0] xrm, input logic [15:0] xexp);
        @(negedge clk);
        a   = xa;
        b   = xb;
        sub = xsub;
        rm  = xrm;
        e   = 1'b1;
        exp_q.push_back(xexp);
    endtask

    task automatic op(input logic [15:0] xa, input logic [15:0] xb, input logic xsub,
                      input logic [1:0] xrm);
        drive(xa, xb, xsub, xrm, fp_ref(xa, xb, xsub, xrm));
    endtask

    // Stall with junk on the inputs; none of it may be captured.
    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk);
            e   = 1'b0;
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            rm  = 2'($urandom);
        end
    endtask

    // Monitor: a result is present once three enabled edges follow a capture.
    initial begin
        forever begin
            @(posedge clk);
            mon_en = e;
            if (!clrn)       mon_vld = 3'b000;
            else if (mon_en) mon_vld = {mon_vld[1:0], 1'b1};
            #1;
            if (clrn && mon_vld[2]) begin
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_underflow: s=%h with no expected entry at %0t", s, $time);
                    end else begin
                        last_exp = exp_q.pop_front();
                        check("stream", s, last_exp);
                    end
                end else begin
                    check("stall_hold", s, last_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, s=%h expected=finish", s);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        clrn = 1'b0;
        e    = 1'b0;
        a    = 16'h0000;
        b    = 16'h0000;
        sub  = 1'b0;
        rm   = 2'b00;
        repeat (2) @(posedge clk);
        #1 check("reset_s", s, 16'h0000);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1 check("idle_after_reset", s, 16'h0000);

        // Streaming, then a 2-cycle stall mid-stream.
        drive(16'h4500, 16'h4700, 1'b0, 2'b00, 16'h4A00);
        drive(16'h4300, 16'hC500, 1'b0, 2'b00, 16'hBE00);
        drive(16'h0001, 16'h0001, 1'b0, 2'b00, 16'h0002);
        stall(2);
        // Overflow in every rounding mode, both signs.
        drive(16'h7BFF, 16'h7BFF, 1'b0, 2'b00, 16'h7C00);
        drive(16'h7BFF, 16'h7BFF, 1'b0, 2'b11, 16'h7BFF);
        drive(16'h7BFF, 16'h7BFF, 1'b0, 2'b01, 16'h7BFF);
        drive(16'h7BFF, 16'h7BFF, 1'b0, 2'b10, 16'h7C00);
        drive(16'hFBFF, 16'hFBFF, 1'b0, 2'b01, 16'hFC00);
        drive(16'hFBFF, 16'hFBFF, 1'b0, 2'b10, 16'hFBFF);
        drive(16'hFBFF, 16'hFBFF, 1'b0, 2'b11, 16'hFBFF);
        // Specials.
        drive(16'h7C00, 16'hFC00, 1'b0, 2'b00, 16'h7E00);
        drive(16'h7C00, 16'h7C00, 1'b1, 2'b00, 16'h7E00);
        drive(16'h7C00, 16'h3C00, 1'b1, 2'b10, 16'h7C00);
        drive(16'h3C00, 16'hFC00, 1'b0, 2'b00, 16'hFC00);
        drive(16'h7E01, 16'h0000, 1'b0, 2'b00, 16'h7E00);
        drive(16'h7C01, 16'h3C00, 1'b0, 2'b11, 16'h7E00);
        // Signed zeros.
        drive(16'h3C00, 16'h3C00, 1'b1, 2'b00, 16'h0000);
        drive(16'h3C00, 16'h3C00, 1'b1, 2'b01, 16'h8000);
        drive(16'h0000, 16'h0000, 1'b0, 2'b01, 16'h0000);
        drive(16'h8000, 16'h8000, 1'b0, 2'b00, 16'h8000);
        drive(16'h8000, 16'h8000, 1'b0, 2'b10, 16'h8000);
        drive(16'h0000, 16'h8000, 1'b0, 2'b01, 16'h8000);
        drive(16'h0000, 16'h8000, 1'b0, 2'b00, 16'h0000);
        // Subnormal carry into normal range; sticky and tie rounding.
        drive(16'h03FF, 16'h0001, 1'b0, 2'b00, 16'h0400);
        drive(16'h3C00, 16'h0001, 1'b0, 2'b10, 16'h3C01);
        drive(16'h3C00, 16'h0001, 1'b0, 2'b00, 16'h3C00);
        drive(16'h3C00, 16'h0001, 1'b1, 2'b00, 16'h3C00);
        drive(16'h3C00, 16'h0001, 1'b1, 2'b11, 16'h3BFF);
        drive(16'h3C00, 16'h1000, 1'b0, 2'b00, 16'h3C00);
        drive(16'h3C01, 16'h1000, 1'b0, 2'b00, 16'h3C02);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 3));
            ra = rand_fp();
            rb = rand_fp();
            if ($urandom_range(0, 3) == 0) rb = {1'($urandom), ra[14:3], 3'($urandom)};
            op(ra, rb, 1'($urandom), 2'($urandom));
        end

        // Reset in the middle of a stream.
        repeat (4) drive(16'h4500, 16'h4700, 1'b0, 2'b00, 16'h4A00);
        @(negedge clk);
        e    = 1'b0;
        clrn = 1'b0;
        exp_q.delete();
        #1 check("reset_mid", s, 16'h0000);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", s, 16'h0000);
        @(negedge clk);
        clrn = 1'b1;
        drive(16'h4500, 16'h4700, 1'b0, 2'b00, 16'h4A00);
        drive(16'h4300, 16'hC500, 1'b0, 2'b00, 16'hBE00);
        drive(16'h0001, 16'h0001, 1'b0, 2'b00, 16'h0002);

        // Drain.
        repeat (3) drive(16'h0000, 16'h0000, 1'b0, 2'b00, 16'h0000);
        @(negedge clk);
        e = 1'b0;
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_16bit_fp_adder.md
Name: pipelined_16bit_fp_adder

Overview:
- IEEE 754 binary16 (half-precision) floating-point adder/subtractor, pipelined over 4 stages with 3 internal register banks.
- Stages: alignment, calculation, normalization, rounding/packing.
- Used as a streaming arithmetic unit: accepts one operand pair per enabled clock and returns the sum 3 enabled clocks later.
- Supports all four IEEE rounding modes, subnormals, infinities and NaN.

Parameters:
- none (format fixed: 1 sign, 5 exponent with bias 15, 10 fraction).

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  asynchronous active-low reset; clears all pipeline registers
- a  input  16  operand A, binary16
- b  input  16  operand B, binary16
- sub  input  1  0 = a+b, 1 = a-b (sign of b inverted before alignment)
- rm  input  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
- e  input  1  pipeline enable; all register banks load only when e=1
- s  output  16  result, binary16
- Positional port order for instantiation: a, b, sub, rm, s, clk, clrn, e.

Behaviour:
- Reset:
  - clrn=0 asynchronously clears every pipeline register, including captured rm, sign, exponent, fraction and special-case flags.
  - While in reset and until the first data reaches the output, s = 16'h0000.
- Pipeline and latency:
  - Operands and rm are captured at a rising edge with e=1.
  - The result for that pair appears on s after the 3rd enabled rising edge.
  - s is combinational from the last register bank; no output register.
  - Throughput is one operation per enabled cycle.
- Enable: e=0 freezes all banks (stall); s holds its value. There is no valid/ready handshake.
- Stage 1, alignment:
  - Unpack both operands; hidden bit = 1 if exp != 0, else 0 (subnormal, effective exponent 1).
  - Swap so the larger magnitude is first.
  - Right-shift the smaller fraction by the exponent difference, keeping guard, round and sticky bits; a shift of 14 or more collapses to sticky only.
  - Detect inf/NaN.
- Stage 2, calculation: add or subtract the aligned significands per the effective operation (sign_a XOR sign_b XOR sub). The result sign is the sign of the larger operand.
- Stage 3, normalization:
  - Leading-zero count, then left shift, or right shift by 1 on carry-out.
  - Adjust the exponent.
  - Exponent underflow produces a subnormal (exp = 0, shift limited).
- Stage 4, rounding and packing:
  - Round per the captured rm using guard/round/sticky.
  - If rounding carries out, re-normalize and increment the exponent.
- Overflow (exp >= 31):
  - RNE → ±inf.
  - RZ → ±max finite (0x7BFF / 0xFBFF).
  - Toward -inf → +max finite / -inf.
  - Toward +inf → +inf / -max finite.
- Specials:
  - Any NaN input, or inf - inf, → canonical quiet NaN 16'h7E00.
  - inf ± finite → that inf.
- Exact-zero results:
  - A sum of exact zero has sign +0, except in mode 01 where it is -0.
  - (+0)+(+0) = +0 and (-0)+(-0) = -0 in all modes.
- Reset mid-operation: all in-flight operations are discarded; s returns to 0x0000 immediately.

Test Plan:
- Reset, then a=4500 (5.0), b=4700 (7.0), sub=0, rm=00, e=1 → s=4A00 (12.0) after 3 rising edges.
- Reset, then a=4300 (3.5), b=C500 (-5.0), rm=00 → s=BE00 (-1.5) after 3 edges.
- a=7BFF, b=7BFF: rm=00 → s=7C00 (+inf); rm=11 → s=7BFF.
- a=7C00, b=FC00 → s=7E00 (NaN).
- a=3C00, b=3C00 with sub=1, rm=00 → s=0000; same with rm=01 → s=8000.
- Streaming and stall:
  - Feed 4500+4700, 4300+C500 and 0001+0001 on consecutive enabled cycles → s = 4A00, BE00, 0002 on consecutive cycles.
  - Drop e for 2 cycles mid-stream → s holds and resumes without loss.
  - Assert clrn mid-stream → s=0000 immediately.
